// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode/decoded-code constants and instruction field positions
package cpu_pkg;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = $clog2(NUM_REGS);
  localparam int INSTR_W  = 16;
  localparam int OP_W     = 4;
  localparam int OP_LSB   = 12;
  localparam int RD_LSB   = 9;
  localparam int RS1_LSB  = 6;
  localparam int RS2_LSB  = 3;
  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_AND = 4'h3;
  localparam logic [OP_W-1:0] OP_OR  = 4'h4;
  localparam logic [7:0] EX_NOP = 8'h00;
  localparam logic [7:0] EX_ADD = 8'h01;
  localparam logic [7:0] EX_SUB = 8'h02;
  localparam logic [7:0] EX_AND = 8'h03;
  localparam logic [7:0] EX_OR  = 8'h04;
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_OR;
  endfunction
  function automatic logic [7:0] op_decode(input logic [OP_W-1:0] op);
    return op == OP_ADD ? EX_ADD :
           op == OP_SUB ? EX_SUB :
           op == OP_AND ? EX_AND :
           op == OP_OR  ? EX_OR  : EX_NOP;
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: Fetch handshake, writeback port and Execute-facing decoded fields
interface decode_stage_if;
  import cpu_pkg::*;
  logic                 in_valid;
  logic [INSTR_W-1:0]   in_instr;
  logic                 in_ready;
  logic                 wb_en;
  logic [REG_AW-1:0]    wb_addr;
  logic [DATA_W-1:0]    wb_data;
  logic                 out_valid;
  logic [7:0]           decoded_instruction;
  logic [DATA_W-1:0]    read_data1;
  logic [DATA_W-1:0]    read_data2;
  logic [REG_AW-1:0]    dest_addr;
  logic                 illegal;
  modport master (
    output in_valid, in_instr, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, decoded_instruction, read_data1, read_data2, dest_addr, illegal
  );
  modport slave (
    input  in_valid, in_instr, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, decoded_instruction, read_data1, read_data2, dest_addr, illegal
  );
endinterface

// File: rtl/decode_stage_reg_file_2r1w.sv
// reg_file_2r1w: 2-read/1-write register file, write-first reads, r0 hardwired to zero
module reg_file_2r1w
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end
  assign rdata1 = raddr1 == '0 ? '0 : (we && waddr == raddr1) ? wdata : regs[raddr1];
  assign rdata2 = raddr2 == '0 ? '0 : (we && waddr == raddr2) ? wdata : regs[raddr2];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode/operand fetch with pending-write scoreboard and registered Execute outputs
module decode_stage
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  decode_stage_if.slave bus
);
  logic [OP_W-1:0]     op;
  logic [REG_AW-1:0]   rd, rs1, rs2;
  logic [NUM_REGS-1:0] pending, live, set_mask, clr_mask;
  logic                hazard, accept;
  logic [DATA_W-1:0]   rdata1, rdata2;
  logic                unused_rsvd;
  assign op  = bus.in_instr[OP_LSB +: OP_W];
  assign rd  = bus.in_instr[RD_LSB +: REG_AW];
  assign rs1 = bus.in_instr[RS1_LSB +: REG_AW];
  assign rs2 = bus.in_instr[RS2_LSB +: REG_AW];
  assign unused_rsvd = ^bus.in_instr[RS2_LSB-1:0];
  // a writeback landing this cycle already resolves its register
  assign clr_mask = bus.wb_en ? NUM_REGS'(1) << bus.wb_addr : '0;
  assign live     = pending & ~clr_mask;
  assign hazard   = live[rs1] | live[rs2] | live[rd];
  assign bus.in_ready = ~hazard;
  assign accept   = bus.in_valid & ~hazard;
  assign set_mask = (accept && op != OP_NOP && op_legal(op) && rd != '0) ? NUM_REGS'(1) << rd : '0;
  reg_file_2r1w u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (bus.wb_en),
    .waddr  (bus.wb_addr),
    .wdata  (bus.wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      pending                 <= '0;
      bus.out_valid           <= 1'b0;
      bus.decoded_instruction <= EX_NOP;
      bus.illegal             <= 1'b0;
      bus.read_data1          <= '0;
      bus.read_data2          <= '0;
      bus.dest_addr           <= '0;
    end else begin
      pending                 <= live | set_mask;
      bus.out_valid           <= accept;
      bus.decoded_instruction <= accept ? op_decode(op) : EX_NOP;
      bus.illegal             <= accept & ~op_legal(op);
      if (accept) begin
        bus.read_data1 <= rdata1;
        bus.read_data2 <= rdata2;
        bus.dest_addr  <= rd;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus random traffic checked against a behavioural model
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset;
  decode_stage_if bus();
  decode_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk = 0;
  bit started = 0;

  logic [7:0] m_regs [8];
  bit         m_pend [8];
  bit         p_rs, p_v, p_we;
  logic [15:0] p_ins;
  logic [2:0]  p_wa;
  logic [7:0]  p_wd;
  bit          e_valid, e_ill, e_ready;
  logic [7:0]  e_dec, e_rd1, e_rd2;
  logic [2:0]  e_dest;

  function automatic bit blocked(input logic [2:0] r, input bit we, input logic [2:0] wa);
    return m_pend[r] && !(we && wa == r);
  endfunction

  function automatic bit hz(input logic [15:0] ins, input bit we, input logic [2:0] wa);
    return blocked(ins[8:6], we, wa) || blocked(ins[5:3], we, wa) || blocked(ins[11:9], we, wa);
  endfunction

  function automatic logic [7:0] rval(input logic [2:0] r);
    if (r == 0) return 8'h00;
    if (p_we && p_wa == r) return p_wd;
    return m_regs[r];
  endfunction

  task automatic commit();
    bit acc;
    logic [3:0] op;
    logic [2:0] rd;
    if (p_rs) begin
      for (int i = 0; i < 8; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
      e_valid = 0; e_ill = 0; e_dec = 0; e_rd1 = 0; e_rd2 = 0; e_dest = 0;
      chk = 1;
      return;
    end
    op  = p_ins[15:12];
    rd  = p_ins[11:9];
    acc = p_v && !hz(p_ins, p_we, p_wa);
    e_valid = acc;
    e_ill   = acc && op > 4;
    e_dec   = (acc && op <= 4) ? {4'h0, op} : 8'h00;
    if (acc) begin
      e_rd1  = rval(p_ins[8:6]);
      e_rd2  = rval(p_ins[5:3]);
      e_dest = rd;
    end
    if (p_we && p_wa != 0) m_regs[p_wa] = p_wd;
    if (p_we) m_pend[p_wa] = 0;
    if (acc && op >= 1 && op <= 4 && rd != 0) m_pend[rd] = 1;
  endtask

  task automatic step(input bit rs, input bit v, input logic [15:0] ins,
                      input bit we, input logic [2:0] wa, input logic [7:0] wd);
    @(posedge clk);
    #1;
    if (started) commit();
    started = 1;
    p_rs = rs; p_v = v; p_ins = ins; p_we = we; p_wa = wa; p_wd = wd;
    reset = rs; bus.in_valid = v; bus.in_instr = ins;
    bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
    e_ready = !hz(ins, we, wa);
    @(negedge clk);
  endtask

  task automatic idle(); step(0, 0, 16'h0000, 0, 0, 0); endtask
  task automatic wb(input logic [2:0] a, input logic [7:0] d); step(0, 0, 16'h0000, 1, a, d); endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      cmp("in_ready", 32'(bus.in_ready), 32'(e_ready));
      cmp("out_valid", 32'(bus.out_valid), 32'(e_valid));
      cmp("decoded", 32'(bus.decoded_instruction), 32'(e_dec));
      cmp("illegal", 32'(bus.illegal), 32'(e_ill));
      cmp("read_data1", 32'(bus.read_data1), 32'(e_rd1));
      cmp("read_data2", 32'(bus.read_data2), 32'(e_rd2));
      cmp("dest_addr", 32'(bus.dest_addr), 32'(e_dest));
    end
  end

  initial begin
    step(1, 0, 16'h0000, 0, 0, 0);
    step(1, 0, 16'h0000, 0, 0, 0);
    idle();
    cmp("lit_reset_valid", 32'(bus.out_valid), 0);
    cmp("lit_reset_ready", 32'(bus.in_ready), 1);
    // basic ADD r3,r1,r2
    wb(1, 8'h05);
    wb(2, 8'h03);
    step(0, 1, 16'h1650, 0, 0, 0);
    cmp("lit_add_ready", 32'(bus.in_ready), 1);
    idle();
    cmp("lit_add_valid", 32'(bus.out_valid), 1);
    cmp("lit_add_dec", 32'(bus.decoded_instruction), 32'h01);
    cmp("lit_add_rd1", 32'(bus.read_data1), 32'h05);
    cmp("lit_add_rd2", 32'(bus.read_data2), 32'h03);
    cmp("lit_add_dest", 32'(bus.dest_addr), 3);
    // RAW on r3 until writeback, then bypass
    step(0, 1, 16'h18C8, 0, 0, 0);
    cmp("lit_raw_stall", 32'(bus.in_ready), 0);
    step(0, 1, 16'h18C8, 0, 0, 0);
    cmp("lit_raw_stall2", 32'(bus.in_ready), 0);
    step(0, 1, 16'h18C8, 1, 3, 8'h08);
    cmp("lit_raw_bypass_ready", 32'(bus.in_ready), 1);
    idle();
    cmp("lit_raw_rd1", 32'(bus.read_data1), 32'h08);
    cmp("lit_raw_rd2", 32'(bus.read_data2), 32'h05);
    cmp("lit_raw_dest", 32'(bus.dest_addr), 4);
    idle();
    cmp("lit_bubble_valid", 32'(bus.out_valid), 0);
    cmp("lit_bubble_dec", 32'(bus.decoded_instruction), 32'h00);
    wb(4, 8'h0D);
    // illegal op does not mark rd pending
    step(0, 1, 16'hAC50, 0, 0, 0);
    step(0, 1, 16'h1FB0, 0, 0, 0);
    cmp("lit_ill_flag", 32'(bus.illegal), 1);
    cmp("lit_ill_dec", 32'(bus.decoded_instruction), 32'h00);
    cmp("lit_ill_valid", 32'(bus.out_valid), 1);
    cmp("lit_ill_nostall", 32'(bus.in_ready), 1);
    idle();
    cmp("lit_after_ill", 32'(bus.illegal), 0);
    cmp("lit_after_ill_dec", 32'(bus.decoded_instruction), 32'h01);
    wb(7, 8'h00);
    // r0 ignores writes and reads zero
    wb(0, 8'hFF);
    step(0, 1, 16'h1A00, 0, 0, 0);
    cmp("lit_r0_ready", 32'(bus.in_ready), 1);
    idle();
    cmp("lit_r0_rd1", 32'(bus.read_data1), 0);
    cmp("lit_r0_rd2", 32'(bus.read_data2), 0);
    wb(5, 8'h00);
    // reset during a stall
    step(0, 1, 16'h1650, 0, 0, 0);
    step(0, 1, 16'h18C8, 0, 0, 0);
    cmp("lit_pre_rst_valid", 32'(bus.out_valid), 1);
    cmp("lit_pre_rst_stall", 32'(bus.in_ready), 0);
    step(1, 1, 16'h18C8, 0, 0, 0);
    step(0, 1, 16'h18C8, 0, 0, 0);
    cmp("lit_rst_valid", 32'(bus.out_valid), 0);
    cmp("lit_rst_ready", 32'(bus.in_ready), 1);
    idle();
    cmp("lit_rst_rd1", 32'(bus.read_data1), 0);
    cmp("lit_rst_rd2", 32'(bus.read_data2), 0);
    wb(4, 8'h00);
    // same-cycle clear and set on r3: set wins
    step(0, 1, 16'h1650, 0, 0, 0);
    step(0, 1, 16'h1650, 1, 3, 8'h11);
    cmp("lit_setwin_ready", 32'(bus.in_ready), 1);
    step(0, 1, 16'h18C8, 0, 0, 0);
    cmp("lit_setwin_stall", 32'(bus.in_ready), 0);
    step(0, 1, 16'h18C8, 1, 3, 8'h22);
    cmp("lit_setwin_release", 32'(bus.in_ready), 1);
    idle();
    cmp("lit_setwin_rd1", 32'(bus.read_data1), 32'h22);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(63) == 0, $urandom_range(3) != 0, 16'($urandom),
           $urandom_range(2) == 0, 3'($urandom), 8'($urandom));
    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
